multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I datapath variant.
- Sequences instruction fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- Drives imm_src to select the immediate format (I/S/B) for the immediate generator, plus all mux selects and write enables.
- Stalls on a memory ready handshake, counts retired instructions and traps on unsupported opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  instruction[6:0] from the instruction register; stable after fetch.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- pc_write  output  1  PC register load enable.
- ir_write  output  1  instruction register load enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register file write enable.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- alu_op  output  2  ALU decoder class: 00 = add, 01 = sub/compare, 10 = funct-decoded.
- result_src  output  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- imm_src  output  2  immediate format: 00 = I (load/addi), 01 = S (store), 10 = B (branch).
- illegal  output  1  sticky trap flag.
- state  output  4  current state encoding, for debug.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, TRAP=10.
- Output defaults: every output not listed for a state is 0.
- Output timing: outputs are combinational from state. pc_write and ir_write also depend on mem_ready and zero.
- Reset: state <= FETCH, retired <= 0, illegal <= 0. While reset is high, all write/request enables are forced to 0. Reset asserted mid-instruction aborts it, with no further writes.
- FETCH: mem_read=1, adr_src=0.
  - When mem_ready=1: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, next state DECODE.
  - Otherwise hold in FETCH with ir_write=0 and pc_write=0.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=10 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BEQ
  - any other opcode -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. imm_src=00 for load, 01 for store. Next state MEMREAD for load, MEMWRITE for store.
- MEMREAD: adr_src=1, mem_read=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then go to FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Hold (mem_write kept high) until mem_ready=1, then go to FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10, then go to ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10, imm_src=00, then go to ALUWB.
- ALUWB: result_src=00, reg_write=1, then go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, then go to FETCH.
- TRAP: illegal=1, all enables 0. Remains in TRAP until reset.
- Latency with mem_ready tied high: load 5 cycles, store 4, R-type 4, I-type 4, beq 3.
- Each mem_ready wait cycle in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- retired increments by 1 on the clock edge leaving MEMWB, ALUWB or BEQ, and leaving MEMWRITE with mem_ready=1.
  - It wraps modulo 2^CNT_W.
  - It never increments in TRAP or during reset.
- mem_read and mem_write are never high in the same cycle.
- reg_write and mem_write are never high in the same cycle.

Test Plan:
- Reset, then hold mem_ready=0 for 3 cycles: state stays 0 with mem_read=1 and ir_write=0. On mem_ready=1: ir_write=1, pc_write=1 for exactly one cycle, then state=1.
- Load (opcode 0000011), mem_ready=1: state sequence 0,1,2,3,4,0. imm_src=00 in MEMADR; reg_write=1 with result_src=01 only in MEMWB; retired goes 0 to 1.
- Store (0100011), mem_ready low 2 cycles in MEMWRITE: sequence 0,1,2,5,5,5,0. imm_src=01 in MEMADR; mem_write high for 3 cycles; reg_write never asserted.
- BEQ (1100011): with zero=1, pc_write=1 in state 9; with zero=0, pc_write=0. imm_src=10 in DECODE; retired increments in both cases.
- Back-to-back R-type (0110011) then addi (0010011): sequences 0,1,6,8 and 0,1,7,8. alu_op=10 in both; alu_src_b 00 vs 01; retired=2.
- Opcode 1111111: state 10, illegal=1 held for 10 cycles, no enables, retired unchanged. Then reset pulsed during MEMREAD of a load: next cycle state=0, retired=0, illegal=0, reg_write never asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/
// execute/memory/writeback over a shared ALU and unified memory port.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [1:0]       imm_src,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        TRAP     = 4'd10
    } state_t;

    state_t           st;
    logic             ill_q;
    logic [CNT_W-1:0] cnt;
    logic             retire;
    logic             is_store;

    // Loads and stores differ only in opcode bit 5 once DECODE has filtered them.
    assign is_store = opcode[5];

    always_comb begin
        retire = (st == MEMWB) || (st == ALUWB) || (st == BEQ) ||
                 ((st == MEMWRITE) && mem_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= FETCH;
            cnt   <= '0;
            ill_q <= 1'b0;
        end else begin
            if (retire)
                cnt <= cnt + CNT_W'(1);
            case (st)
                FETCH:    if (mem_ready) st <= DECODE;
                DECODE: begin
                    case (opcode)
                        7'b0000011, 7'b0100011: st <= MEMADR;
                        7'b0110011:             st <= EXEC_R;
                        7'b0010011:             st <= EXEC_I;
                        7'b1100011:             st <= BEQ;
                        default: begin
                            st    <= TRAP;
                            ill_q <= 1'b1;
                        end
                    endcase
                end
                MEMADR:   st <= is_store ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready) st <= MEMWB;
                MEMWB:    st <= FETCH;
                MEMWRITE: if (mem_ready) st <= FETCH;
                EXEC_R:   st <= ALUWB;
                EXEC_I:   st <= ALUWB;
                ALUWB:    st <= FETCH;
                BEQ:      st <= FETCH;
                TRAP:     st <= TRAP;
                default:  st <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_src    = 2'b00;
        case (st)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = is_store ? 2'b01 : 2'b00;
            end
            MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
            default: ;
        endcase
        // Reset aborts any in-flight instruction: no writes or requests escape.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign illegal = ill_q;
    assign state   = st;
    assign retired = cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control; a second instance with a
// 2-bit counter shares the stimulus to exercise retired-count wraparound.
module tb_multicycle_control;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = LD;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        pc_write2, ir_write2, adr_src2, mem_read2, mem_write2, reg_write2, illegal2;
    logic [1:0]  alu_src_a2, alu_src_b2, alu_op2, result_src2, imm_src2;
    logic [3:0]  state2;
    logic [1:0]  retired2;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
        .illegal(illegal), .state(state), .retired(retired)
    );

    multicycle_control #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write2), .ir_write(ir_write2), .adr_src(adr_src2), .mem_read(mem_read2),
        .mem_write(mem_write2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .result_src(result_src2), .imm_src(imm_src2),
        .illegal(illegal2), .state(state2), .retired(retired2)
    );

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;  // {pcw,irw,adr,mr,mw,rw,asa,asb,aop,rs,imm}
        logic        ill;
        logic [31:0] ret;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [6:0] op, input logic z,
                                input logic rdy, input logic [3:0] st,
                                input logic pcw, input logic irw, input logic adr,
                                input logic mr, input logic mw, input logic rw,
                                input logic [1:0] asa, input logic [1:0] asb,
                                input logic [1:0] aop, input logic [1:0] rs,
                                input logic [1:0] imm, input logic ill,
                                input logic [31:0] ret);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.st = st;
        v.ctl = {pcw, irw, adr, mr, mw, rw, asa, asb, aop, rs, imm};
        v.ill = ill; v.ret = ret;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [15:0] act;
        logic [1:0]  ret2_exp;
        @(negedge clk);
        reset = v.rst; opcode = v.op; zero = v.z; mem_ready = v.rdy;
        #1;
        act = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src};
        n_cmp++;
        if (state !== v.st || act !== v.ctl || illegal !== v.ill) begin
            n_bad++;
            $display("FAIL %s outputs: got st=%0d ctl=%h ill=%b, required st=%0d ctl=%h ill=%b",
                     tag, state, act, illegal, v.st, v.ctl, v.ill);
        end
        n_cmp++;
        if (retired !== v.ret) begin
            n_bad++;
            $display("FAIL %s retired: got %0d, required %0d", tag, retired, v.ret);
        end
        ret2_exp = v.ret[1:0];
        n_cmp++;
        if (retired2 !== ret2_exp) begin
            n_bad++;
            $display("FAIL %s retired_w2: got %0d, required %0d", tag, retired2, ret2_exp);
        end
        n_cmp++;
        if ((mem_read & mem_write) || (reg_write & mem_write)) begin
            n_bad++;
            $display("FAIL %s exclusive: got mr=%b mw=%b rw=%b, required no overlap",
                     tag, mem_read, mem_write, reg_write);
        end
    endtask

    vec_t tbl[$];

    initial begin
        // rst op z rdy | st pcw irw adr mr mw rw asa asb aop rs imm ill ret
        tbl.push_back(mk(1, LD, 0, 0,  0, 0,0,0,0,0,0, 0,0,0,0,0, 0, 0));
        tbl.push_back(mk(0, LD, 0, 0,  0, 0,0,0,1,0,0, 0,0,0,0,0, 0, 0));
        tbl.push_back(mk(0, LD, 0, 0,  0, 0,0,0,1,0,0, 0,0,0,0,0, 0, 0));
        tbl.push_back(mk(0, LD, 0, 0,  0, 0,0,0,1,0,0, 0,0,0,0,0, 0, 0));
        tbl.push_back(mk(0, LD, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 0));
        tbl.push_back(mk(0, LD, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 0));
        tbl.push_back(mk(0, LD, 0, 1,  2, 0,0,0,0,0,0, 2,1,0,0,0, 0, 0));
        tbl.push_back(mk(0, LD, 0, 1,  3, 0,0,1,1,0,0, 0,0,0,0,0, 0, 0));
        tbl.push_back(mk(0, LD, 0, 1,  4, 0,0,0,0,0,1, 0,0,0,1,0, 0, 0));
        tbl.push_back(mk(0, ST, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 1));
        tbl.push_back(mk(0, ST, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 1));
        tbl.push_back(mk(0, ST, 0, 1,  2, 0,0,0,0,0,0, 2,1,0,0,1, 0, 1));
        tbl.push_back(mk(0, ST, 0, 0,  5, 0,0,1,0,1,0, 0,0,0,0,0, 0, 1));
        tbl.push_back(mk(0, ST, 0, 0,  5, 0,0,1,0,1,0, 0,0,0,0,0, 0, 1));
        tbl.push_back(mk(0, ST, 0, 1,  5, 0,0,1,0,1,0, 0,0,0,0,0, 0, 1));
        tbl.push_back(mk(0, BR, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 2));
        tbl.push_back(mk(0, BR, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 2));
        tbl.push_back(mk(0, BR, 1, 1,  9, 1,0,0,0,0,0, 2,0,1,0,0, 0, 2));
        tbl.push_back(mk(0, BR, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 3));
        tbl.push_back(mk(0, BR, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 3));
        tbl.push_back(mk(0, BR, 0, 1,  9, 0,0,0,0,0,0, 2,0,1,0,0, 0, 3));
        tbl.push_back(mk(0, RT, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 4));
        tbl.push_back(mk(0, RT, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 4));
        tbl.push_back(mk(0, RT, 0, 1,  6, 0,0,0,0,0,0, 2,0,2,0,0, 0, 4));
        tbl.push_back(mk(0, RT, 0, 1,  8, 0,0,0,0,0,1, 0,0,0,0,0, 0, 4));
        tbl.push_back(mk(0, IT, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 5));
        tbl.push_back(mk(0, IT, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 5));
        tbl.push_back(mk(0, IT, 0, 1,  7, 0,0,0,0,0,0, 2,1,2,0,0, 0, 5));
        tbl.push_back(mk(0, IT, 0, 1,  8, 0,0,0,0,0,1, 0,0,0,0,0, 0, 5));
        tbl.push_back(mk(0, BAD, 0, 1, 0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 6));
        tbl.push_back(mk(0, BAD, 0, 1, 1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 6));
        tbl.push_back(mk(0, BAD, 0, 1, 10, 0,0,0,0,0,0, 0,0,0,0,0, 1, 6));

        @(negedge clk);
        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Trap must hold regardless of handshake or zero flag.
        for (int i = 0; i < 10; i++) begin
            logic zb, rb;
            zb = (i / 2) % 2 == 1;
            rb = i % 2 == 1;
            apply(mk(0, BAD, zb, rb, 10, 0,0,0,0,0,0, 0,0,0,0,0, 1, 6),
                  $sformatf("trap%0d", i));
        end

        // Reset leaves TRAP; retire one R-type so the abort below must clear it.
        apply(mk(1, BAD, 0, 0, 10, 0,0,0,0,0,0, 0,0,0,0,0, 1, 6), "rst_trap");
        apply(mk(0, RT, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 0), "r_fetch");
        apply(mk(0, RT, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 0), "r_dec");
        apply(mk(0, RT, 0, 1,  6, 0,0,0,0,0,0, 2,0,2,0,0, 0, 0), "r_exec");
        apply(mk(0, RT, 0, 1,  8, 0,0,0,0,0,1, 0,0,0,0,0, 0, 0), "r_wb");
        apply(mk(0, LD, 0, 1,  0, 1,1,0,1,0,0, 0,2,0,2,0, 0, 1), "ld_fetch");
        apply(mk(0, LD, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,2, 0, 1), "ld_dec");
        apply(mk(0, LD, 0, 1,  2, 0,0,0,0,0,0, 2,1,0,0,0, 0, 1), "ld_adr");
        apply(mk(0, LD, 0, 0,  3, 0,0,1,1,0,0, 0,0,0,0,0, 0, 1), "ld_wait");
        apply(mk(1, LD, 0, 1,  3, 0,0,1,0,0,0, 0,0,0,0,0, 0, 1), "ld_abort");
        apply(mk(0, LD, 0, 0,  0, 0,0,0,1,0,0, 0,0,0,0,0, 0, 0), "post_rst0");
        apply(mk(0, LD, 0, 0,  0, 0,0,0,1,0,0, 0,0,0,0,0, 0, 0), "post_rst1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
